// File: rtl/radix4_mult_seq.sv
// Iterative unsigned multiplier: retires two multiplier bits per BUSY cycle with valid/ready on both sides.
// Optional RADIX4_MULT_SEQ_EARLY_EXIT_EN ends BUSY as soon as no multiplier bits remain.
module radix4_mult_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  localparam int unsigned STEPS = (WIDTH + 1) / 2;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned BW    = 2 * STEPS;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   a_sh_q, a_sh_d;
  logic [BW-1:0]   b_sh_q, b_sh_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   out_p_q, out_p_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [PW-1:0]   pp;
  logic [PW-1:0]   acc_sum;
  logic [BW-1:0]   b_next;
  logic            last_step;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    cnt_d     = cnt_q;
    out_p_d   = out_p_q;

    pp        = (b_sh_q[0] ? a_sh_q : '0) + (b_sh_q[1] ? (a_sh_q << 1) : '0);
    acc_sum   = acc_q + pp;
    b_next    = b_sh_q >> 2;
`ifdef RADIX4_MULT_SEQ_EARLY_EXIT_EN
    last_step = (cnt_q == CW'(STEPS - 1)) || (b_next == '0);
`else
    last_step = (cnt_q == CW'(STEPS - 1));
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_sh_d  = PW'(in_a);
          b_sh_d  = BW'(in_b);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d  = acc_sum;
        a_sh_d = a_sh_q << 2;
        b_sh_d = b_next;
        cnt_d  = cnt_q + CW'(1);
        if (last_step) begin
          out_p_d = acc_sum;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      cnt_q       <= '0;
      out_p_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      cnt_q       <= cnt_d;
      out_p_q     <= out_p_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign busy      = busy_q;

endmodule
